hs4_sender: RTL and testbench

Synthesizable, parametrised four-phase (return-to-zero) handshake sender. Accepts words on a local valid/ready push port and buffers them in a DEPTH-entry FIFO. Each word is transferred to a remote destination over a req/ack/data link: data is stable from req rise to req fall, and the link returns to zero before the next word. It is the transmitting end of the team's ready/ack link, generalised in data width, buffering, ack synchronisation, hold time and timeout supervision.

---
 rtl/hs4_pkg.sv | 11 +
 rtl/hs4_fifo.sv | 41 ++++
 rtl/hs4_sender.sv | 127 ++++++++++++
 tb/tb_hs4_sender.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs4_pkg.sv
// hs4_pkg: shared state encoding and counter widths for the four-phase sender.
package hs4_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        ERR  = 2'd3
    } state_t;
    localparam int XFER_CNT_W = 16;
    localparam int TO_CNT_W   = 8;
endpackage

// File: rtl/hs4_fifo.sv
// hs4_fifo: synchronous FIFO with combinational head read and occupancy level.
module hs4_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;
    assign o_level = r_wptr - r_rptr;
    assign o_full  = o_level[AW];
    assign o_empty = (r_wptr == r_rptr);
    assign o_data  = r_mem[r_rptr[AW-1:0]];
    // a full FIFO refuses the push even if the head leaves in the same cycle
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/hs4_sender.sv
// hs4_sender: FIFO-buffered four-phase req/ack link transmitter.
// Define HS4_TIMEOUT_EN to add ack wait supervision, the ERR state and err/timeout_cnt.
module hs4_sender
    import hs4_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   req,
    output logic [WIDTH-1:0]       data_out,
    input  logic                   ack,
    output logic [$clog2(DEPTH):0] level,
    output logic [XFER_CNT_W-1:0]  xfer_cnt,
    output logic                   err,
    input  logic                   err_clr,
    output logic [TO_CNT_W-1:0]    timeout_cnt
);
    state_t                  r_state;
    logic                    r_req;
    logic [WIDTH-1:0]        r_data_out;
    logic [7:0]              r_hold_cnt;
    logic [XFER_CNT_W-1:0]   r_xfer_cnt;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic                    w_ack_s;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_timeout;
    logic                    w_release;
    logic [WIDTH-1:0]        w_head;
    assign w_ack_s   = r_ack_sync[SYNC_STAGES-1];
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_release = w_ack_s && (r_hold_cnt == 8'(HOLD_CYCLES));
    assign in_ready  = !w_full;
    assign req       = r_req;
    assign data_out  = r_data_out;
    assign xfer_cnt  = r_xfer_cnt;
    hs4_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ack_sync <= '0;
        else r_ack_sync <= (r_ack_sync << 1) | SYNC_STAGES'(ack);
    end
`ifdef HS4_TIMEOUT_EN
    logic [15:0]         r_wait_cnt;
    logic                r_err;
    logic [TO_CNT_W-1:0] r_to_cnt;
    logic                w_waiting;
    logic                w_leave;
    assign w_waiting   = (r_state == REQ) || (r_state == REL);
    assign w_timeout   = w_waiting && (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign w_leave     = w_timeout || ((r_state == REQ) && w_release) || ((r_state == REL) && !w_ack_s);
    assign err         = r_err;
    assign timeout_cnt = r_to_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_wait_cnt <= (w_waiting && !w_leave) ? r_wait_cnt + 16'd1 : 16'd0;
            if (w_timeout) begin
                r_err <= 1'b1;
                if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT_CYCLES < 4);
    assign w_timeout   = 1'b0;
    assign err         = 1'b0;
    assign timeout_cnt = '0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_data_out <= '0;
            r_hold_cnt <= '0;
            r_xfer_cnt <= '0;
        end else if (w_timeout) begin
            r_state    <= ERR;
            r_req      <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (!w_empty) begin
                    r_data_out <= w_head;
                    r_req      <= 1'b1;
                    r_state    <= REQ;
                end
                REQ: if (w_release) begin
                    r_req      <= 1'b0;
                    r_hold_cnt <= '0;
                    r_state    <= REL;
                end else begin
                    r_hold_cnt <= w_ack_s ? r_hold_cnt + 8'd1 : 8'd0;
                end
                REL: if (!w_ack_s) begin
                    r_xfer_cnt <= r_xfer_cnt + XFER_CNT_W'(1);
                    r_state    <= IDLE;
                end
                default: if (err_clr && !w_ack_s) r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs4_sender.sv
// tb_hs4_sender: directed bench for hs4_sender (main instance HOLD=0, second instance HOLD=3).
module tb_hs4_sender;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        req;
    logic [7:0]  data_out;
    logic        ack = 1'b0;
    logic [2:0]  level;
    logic [15:0] xfer_cnt;
    logic        err;
    logic        err_clr = 1'b0;
    logic [7:0]  timeout_cnt;
    logic        h_in_valid = 1'b0;
    logic        h_in_ready;
    logic [7:0]  h_in_data = 8'h00;
    logic        h_req;
    logic [7:0]  h_data_out;
    logic        h_ack = 1'b0;
    logic [2:0]  h_level;
    logic [15:0] h_xfer_cnt;
    logic        h_err;
    logic [7:0]  h_timeout_cnt;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    bit          ack_en = 1'b1;
    int          hi_cnt = 0;
    logic [7:0]  got[$];
    int          rise_cyc[$];
    int          stab_err = 0;
    logic        prev_req = 1'b0;
    logic [7:0]  last_d = 8'h00;
    logic [15:0] exp_xfer = 16'd0;

    always #5 clk = ~clk;

    hs4_sender #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .HOLD_CYCLES(0), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .req(req), .data_out(data_out), .ack(ack), .level(level), .xfer_cnt(xfer_cnt),
        .err(err), .err_clr(err_clr), .timeout_cnt(timeout_cnt)
    );

    hs4_sender #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .HOLD_CYCLES(3), .TIMEOUT_CYCLES(64)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
        .req(h_req), .data_out(h_data_out), .ack(h_ack), .level(h_level), .xfer_cnt(h_xfer_cnt),
        .err(h_err), .err_clr(1'b0), .timeout_cnt(h_timeout_cnt)
    );

    // destination: raises ack ack_delay cycles after req rises, drops it as soon as req is low
    initial forever begin
        @(posedge clk);
        #2;
        if (!req) begin
            ack = 1'b0;
            hi_cnt = 0;
        end else begin
            if (ack_en && hi_cnt >= ack_delay) ack = 1'b1;
            hi_cnt++;
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        h_ack = h_req;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // link monitor: captures each word at req rise and flags data_out changing while req is high
    initial forever begin
        @(negedge clk);
        if (req && !prev_req) begin
            got.push_back(data_out);
            rise_cyc.push_back(cyc);
        end else if (req && data_out !== last_d) begin
            stab_err++;
        end
        prev_req = req;
        last_d = data_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        in_valid = 1'b1;
        in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_xfer(input logic [15:0] tgt, input int budget);
        int n = 0;
        while (xfer_cnt !== tgt && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (xfer_cnt !== tgt) begin
            errors++;
            $display("FAIL wait_xfer: xfer_cnt=%0d want %0d after %0d cycles", xfer_cnt, tgt, budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if (req !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_reset: req=%0b level=%0d in_ready=%0b want 0 0 1", req, level, in_ready);
        end
        rst = 1'b0;
        step();
        checks++;
        if (req !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_link: req=%0b data_out=%h want 0 00", req, data_out);
        end
        checks++;
        if (in_ready !== 1'b1 || level !== 3'd0) begin
            errors++;
            $display("FAIL reset_fifo: in_ready=%0b level=%0d want 1 0", in_ready, level);
        end
        checks++;
        if (xfer_cnt !== 16'd0 || err !== 1'b0 || timeout_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: xfer=%0d err=%0b to=%0d want 0 0 0", xfer_cnt, err, timeout_cnt);
        end
    endtask

    task automatic test_single();
        ack_en = 1'b1;
        ack_delay = 3;
        got.delete();
        stab_err = 0;
        push1(8'hA5);
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL single_req_t1: req=%0b want 0", req);
        end
        step();
        checks++;
        if (req !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_req_t2: req=%0b data_out=%h want 1 a5", req, data_out);
        end
        repeat (5) step();
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL single_req_t7: req=%0b want 1", req);
        end
        step();
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL single_req_fall_t8: req=%0b want 0", req);
        end
        repeat (2) step();
        checks++;
        if (xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL single_xfer_t10: xfer_cnt=%0d want 0", xfer_cnt);
        end
        step();
        exp_xfer = 16'd1;
        checks++;
        if (xfer_cnt !== exp_xfer) begin
            errors++;
            $display("FAIL single_xfer_t11: xfer_cnt=%0d want %0d", xfer_cnt, exp_xfer);
        end
        checks++;
        if (got.size() != 1 || got[0] !== 8'hA5 || stab_err != 0) begin
            errors++;
            $display("FAIL single_data: words=%0d stab_err=%0d want 1 word a5 stable", got.size(), stab_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] max_lvl = 3'd0;
        bit rdy_ok = 1'b1;
        ack_delay = 1;
        got.delete();
        rise_cyc.delete();
        stab_err = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i + 1);
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            step();
            if (level > max_lvl) max_lvl = level;
        end
        in_valid = 1'b0;
        repeat (4) begin
            step();
            if (level > max_lvl) max_lvl = level;
        end
        checks++;
        if (!rdy_ok) begin
            errors++;
            $display("FAIL b2b_in_ready: in_ready dropped during pushes, want constant 1");
        end
        checks++;
        if (max_lvl !== 3'd3) begin
            errors++;
            $display("FAIL b2b_level_peak: got %0d want 3", max_lvl);
        end
        exp_xfer = exp_xfer + 16'd4;
        wait_xfer(exp_xfer, 200);
        checks++;
        if (got.size() != 4 || got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3 || got[3] !== 8'd4) begin
            errors++;
            $display("FAIL b2b_order: got %0d words first=%h want 01 02 03 04", got.size(), got.size() > 0 ? got[0] : 8'hxx);
        end
        checks++;
        if (rise_cyc.size() != 4 || rise_cyc[1] - rise_cyc[0] != 8 || rise_cyc[3] - rise_cyc[2] != 8) begin
            errors++;
            $display("FAIL b2b_period: req rises %0d apart want 8", rise_cyc.size() > 1 ? rise_cyc[1] - rise_cyc[0] : -1);
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL b2b_stable: data_out changed %0d times while req high want 0", stab_err);
        end
    endtask

    task automatic test_full();
        ack_en = 1'b0;
        got.delete();
        push1(8'h10);
        step();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h11 + i);
            checks++;
            if (in_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_in_ready_%0d: got %0b want %0b", i, in_ready, (i < 4));
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd4 || req !== 1'b1) begin
            errors++;
            $display("FAIL full_level: level=%0d req=%0b want 4 1", level, req);
        end
        ack_en = 1'b1;
        exp_xfer = exp_xfer + 16'd5;
        wait_xfer(exp_xfer, 300);
        repeat (10) step();
        checks++;
        if (got.size() != 5 || got[0] !== 8'h10 || got[1] !== 8'h11 || got[2] !== 8'h12
            || got[3] !== 8'h13 || got[4] !== 8'h14) begin
            errors++;
            $display("FAIL full_delivered: got %0d words last=%h want 10 11 12 13 14", got.size(),
                     got.size() > 0 ? got[got.size()-1] : 8'hxx);
        end
        checks++;
        if (level !== 3'd0 || xfer_cnt !== exp_xfer) begin
            errors++;
            $display("FAIL full_drain: level=%0d xfer=%0d want 0 %0d", level, xfer_cnt, exp_xfer);
        end
    endtask

    task automatic test_hold();
        h_in_valid = 1'b1;
        h_in_data = 8'h3C;
        step();
        h_in_valid = 1'b0;
        step();
        checks++;
        if (h_req !== 1'b1 || h_data_out !== 8'h3C) begin
            errors++;
            $display("FAIL hold_rise: req=%0b data=%h want 1 3c", h_req, h_data_out);
        end
        repeat (5) step();
        checks++;
        if (h_req !== 1'b1) begin
            errors++;
            $display("FAIL hold_still_high: req=%0b want 1", h_req);
        end
        step();
        checks++;
        if (h_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_fall: req=%0b want 0", h_req);
        end
        repeat (6) step();
        checks++;
        if (h_xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL hold_xfer: xfer_cnt=%0d want 1", h_xfer_cnt);
        end
    endtask

`ifdef HS4_TIMEOUT_EN
    task automatic test_timeout();
        ack_en = 1'b0;
        push1(8'h77);
        step();
        repeat (15) step();
        checks++;
        if (req !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_before: req=%0b err=%0b want 1 0", req, err);
        end
        step();
        checks++;
        if (req !== 1'b0 || err !== 1'b1 || timeout_cnt !== 8'd1) begin
            errors++;
            $display("FAIL timeout_err: req=%0b err=%0b to=%0d want 0 1 1", req, err, timeout_cnt);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b0 || xfer_cnt !== exp_xfer) begin
            errors++;
            $display("FAIL timeout_clear: err=%0b xfer=%0d want 0 %0d", err, xfer_cnt, exp_xfer);
        end
        ack_en = 1'b1;
        got.delete();
        push1(8'h78);
        exp_xfer = exp_xfer + 16'd1;
        wait_xfer(exp_xfer, 100);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h78 || timeout_cnt !== 8'd1) begin
            errors++;
            $display("FAIL timeout_next: words=%0d to=%0d want one word 78 and to 1", got.size(), timeout_cnt);
        end
    endtask
`else
    task automatic test_no_timeout();
        ack_en = 1'b0;
        got.delete();
        push1(8'h77);
        repeat (40) step();
        checks++;
        if (req !== 1'b1 || err !== 1'b0 || timeout_cnt !== 8'd0) begin
            errors++;
            $display("FAIL notimeout_wait: req=%0b err=%0b to=%0d want 1 0 0", req, err, timeout_cnt);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (req !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL notimeout_clr: req=%0b err=%0b want 1 0", req, err);
        end
        ack_en = 1'b1;
        exp_xfer = exp_xfer + 16'd1;
        wait_xfer(exp_xfer, 100);
        checks++;
        if (got.size() != 1 || got[0] !== 8'h77) begin
            errors++;
            $display("FAIL notimeout_word: words=%0d want one word 77", got.size());
        end
    endtask
`endif

    task automatic test_reset_mid();
        ack_en = 1'b0;
        push1(8'h55);
        push1(8'h56);
        checks++;
        if (req !== 1'b1 || level !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_pre: req=%0b level=%0d want 1 1", req, level);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0 || level !== 3'd0 || xfer_cnt !== 16'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: req=%0b level=%0d xfer=%0d err=%0b want 0 0 0 0", req, level, xfer_cnt, err);
        end
        step();
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (3) step();
        checks++;
        if (req !== 1'b0 || in_ready !== 1'b1 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_after: req=%0b in_ready=%0b data=%h want 0 1 00", req, in_ready, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_hold();
`ifdef HS4_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
